// File: rtl/fp_add_ctrl.sv
// Sequencer for a single-precision IEEE-754 add around an external sign-magnitude mantissa adder.
// Flushes denormals, truncates shifted-out bits, and normalises one bit per cycle.
module fp_add_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic        add_sA,
  output logic        add_sB,
  output logic [23:0] add_mA,
  output logic [23:0] add_mB,
  input  logic [24:0] add_result,
  input  logic        add_s
);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} stateT;

  stateT       stateQ, stateD;
  logic        sAQ, sAD, sBQ, sBD, signQ, signD;
  logic [7:0]  eAQ, eAD, eBQ, eBD, expQ, expD;
  logic [23:0] mAQ, mAD, mBQ, mBD;
  logic [24:0] sumQ, sumD;
  logic [31:0] resultQ, resultD;

  logic        aNan, bNan, aInf, bInf, aZero, bZero;
  logic        swap;
  logic [7:0]  expDiff, expDec;
  logic [8:0]  expInc;
  logic [23:0] mSmall, mShifted;

  assign aZero = (a[30:23] == 8'd0);
  assign bZero = (b[30:23] == 8'd0);
  assign aInf  = (&a[30:23]) && !(|a[22:0]);
  assign bInf  = (&b[30:23]) && !(|b[22:0]);
  assign aNan  = (&a[30:23]) && (|a[22:0]);
  assign bNan  = (&b[30:23]) && (|b[22:0]);

  assign swap     = (eBQ > eAQ);
  assign expDiff  = swap ? (eBQ - eAQ) : (eAQ - eBQ);
  assign mSmall   = swap ? mAQ : mBQ;
  assign mShifted = (expDiff >= 8'd24) ? 24'd0 : (mSmall >> expDiff);
  assign expInc   = {1'b0, expQ} + 9'd1;
  assign expDec   = expQ - 8'd1;

  always_comb begin
    stateD  = stateQ;
    sAD     = sAQ;
    sBD     = sBQ;
    eAD     = eAQ;
    eBD     = eBQ;
    mAD     = mAQ;
    mBD     = mBQ;
    expD    = expQ;
    sumD    = sumQ;
    signD   = signQ;
    resultD = resultQ;
    unique case (stateQ)
      StIdle: begin
        if (in_valid) begin
          sAD    = a[31];
          sBD    = b[31];
          eAD    = a[30:23];
          eBD    = b[30:23];
          mAD    = aZero ? 24'd0 : {1'b1, a[22:0]};
          mBD    = bZero ? 24'd0 : {1'b1, b[22:0]};
          stateD = StDone;
          if (aNan || bNan || (aInf && bInf && (a[31] != b[31]))) begin
            resultD = 32'h7FC0_0000;
          end else if (aInf) begin
            resultD = a;
          end else if (bInf) begin
            resultD = b;
          end else if (aZero && bZero) begin
            resultD = 32'h0000_0000;
          end else begin
            stateD = StAlign;
          end
        end
      end
      StAlign: begin
        // A always ends up holding the operand with the larger (or equal) exponent.
        sAD    = swap ? sBQ : sAQ;
        sBD    = swap ? sAQ : sBQ;
        mAD    = swap ? mBQ : mAQ;
        mBD    = mShifted;
        expD   = swap ? eBQ : eAQ;
        stateD = StAdd;
      end
      StAdd: begin
        sumD   = add_result;
        signD  = add_s;
        stateD = StNorm;
      end
      StNorm: begin
        if (sumQ == 25'd0) begin
          resultD = 32'h0000_0000;
          stateD  = StDone;
        end else if (sumQ[24]) begin
          sumD   = sumQ >> 1;
          expD   = expInc[7:0];
          stateD = StDone;
          if (expInc == 9'd255) begin
            resultD = {signQ, 8'hFF, 23'd0};
          end else begin
            resultD = {signQ, expInc[7:0], sumQ[23:1]};
          end
        end else if (sumQ[23]) begin
          resultD = {signQ, expQ, sumQ[22:0]};
          stateD  = StDone;
        end else begin
          sumD = {sumQ[23:0], 1'b0};
          expD = expDec;
          if (expDec == 8'd0) begin
            resultD = 32'h0000_0000;
            stateD  = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= StIdle;
      sAQ     <= 1'b0;
      sBQ     <= 1'b0;
      eAQ     <= 8'd0;
      eBQ     <= 8'd0;
      mAQ     <= 24'd0;
      mBQ     <= 24'd0;
      expQ    <= 8'd0;
      sumQ    <= 25'd0;
      signQ   <= 1'b0;
      resultQ <= 32'd0;
    end else begin
      stateQ  <= stateD;
      sAQ     <= sAD;
      sBQ     <= sBD;
      eAQ     <= eAD;
      eBQ     <= eBD;
      mAQ     <= mAD;
      mBQ     <= mBD;
      expQ    <= expD;
      sumQ    <= sumD;
      signQ   <= signD;
      resultQ <= resultD;
    end
  end

  assign in_ready  = (stateQ == StIdle);
  assign busy      = (stateQ != StIdle);
  assign out_valid = (stateQ == StDone);
  assign result    = resultQ;
  assign add_sA    = sAQ;
  assign add_sB    = sBQ;
  assign add_mA    = mAQ;
  assign add_mB    = mBQ;

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Bench for fp_add_ctrl: directed spec vectors plus randomized operands checked against
// an arithmetic reference model, including latency, backpressure and mid-operation reset.
module tb_fp_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic        add_sA, add_sB;
  logic [23:0] add_mA, add_mB;
  logic [24:0] add_result;
  logic        add_s;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  fp_add_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy),
    .add_sA     (add_sA),
    .add_sB     (add_sB),
    .add_mA     (add_mA),
    .add_mB     (add_mB),
    .add_result (add_result),
    .add_s      (add_s)
  );

  // External sign-magnitude adder; equal magnitudes with differing signs give +0.
  always_comb begin
    add_result = 25'd0;
    add_s      = 1'b0;
    if (add_sA == add_sB) begin
      add_result = {1'b0, add_mA} + {1'b0, add_mB};
      add_s      = add_sA;
    end else if (add_mA >= add_mB) begin
      add_result = {1'b0, add_mA} - {1'b0, add_mB};
      add_s      = (add_mA == add_mB) ? 1'b0 : add_sA;
    end else begin
      add_result = {1'b0, add_mB} - {1'b0, add_mA};
      add_s      = add_sB;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: real-valued style add on integer mantissas, then count normalisation steps.
  function automatic void refModel(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output int lat);
    int          ex, ey, e, d, k, tmpE;
    logic        sx, sy, neg, tmpS;
    logic [63:0] mx, my, mag, tmpM;
    longint      sum;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = y[31];
    mx = (ex == 0) ? 64'd0 : {40'd0, 1'b1, x[22:0]};
    my = (ey == 0) ? 64'd0 : {40'd0, 1'b1, y[22:0]};
    lat = 1;
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 255 && sx != sy)) begin
      r = 32'h7FC0_0000;
      return;
    end
    if (ex == 255) begin r = x; return; end
    if (ey == 255) begin r = y; return; end
    if (ex == 0 && ey == 0) begin r = 32'h0; return; end
    if (ey > ex) begin
      tmpE = ex; ex = ey; ey = tmpE;
      tmpM = mx; mx = my; my = tmpM;
      tmpS = sx; sx = sy; sy = tmpS;
    end
    d  = ex - ey;
    my = (d >= 24) ? 64'd0 : my / (64'd1 << d);
    sum = (sx ? -longint'(mx) : longint'(mx)) + (sy ? -longint'(my) : longint'(my));
    neg = (sum < 0);
    mag = neg ? 64'(-sum) : 64'(sum);
    e   = ex;
    lat = 4;
    if (mag == 0) begin
      r = 32'h0;
    end else if (mag >= (64'd1 << 24)) begin
      e = e + 1;
      mag = mag / 2;
      r = (e == 255) ? {neg, 8'hFF, 23'd0} : {neg, 8'(e), mag[22:0]};
    end else begin
      k = 0;
      while (mag < (64'd1 << 23) && e > 0) begin
        mag = mag * 2;
        e = e - 1;
        k = k + 1;
      end
      if (e == 0) begin
        r   = 32'h0;
        lat = 3 + k;
      end else begin
        r   = {neg, 8'(e), mag[22:0]};
        lat = 4 + k;
      end
    end
  endfunction

  task automatic runOp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expRes,
                       input int expLat, input int hold, input string tag);
    int lat;
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".result"}, result, expRes);
    check({tag, ".latency"}, 32'(lat), 32'(expLat));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, ".holdValid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".holdResult"}, result, expRes);
      check({tag, ".holdReady"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drained"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] x, y, r;
    int          lat, ea, eb, mode;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'h0;
    b         = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.outValid", {31'd0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.adder", {6'd0, add_sA, add_sB, add_mA}, 32'd0);
    check("rst.mB", {8'd0, add_mB}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst.inReady", {31'd0, in_ready}, 32'd1);

    runOp(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, 0, "onePlusOne");
    runOp(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4, 0, "cancel");
    runOp(32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 6, 0, "twoShifts");
    runOp(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 4, 0, "farAlign");
    runOp(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4, 0, "overflow");
    runOp(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1, 5, "infMinusInf");
    runOp(32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 1, 0, "nan");
    runOp(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1, 0, "negInf");
    runOp(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 0, "zeroZero");
    runOp(32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000, 4, 2, "zeroPlusX");

    // Abort in NORM: 1.0 + -0.75 needs two left shifts.
    in_valid = 1'b1;
    a = 32'h3F80_0000;
    b = 32'hBF40_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort.alignedMA", {8'd0, add_mA}, 32'h0080_0000);
    check("abort.alignedMB", {8'd0, add_mB}, 32'h0060_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort.outValid", {31'd0, out_valid}, 32'd0);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.mA", {8'd0, add_mA}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort.inReady", {31'd0, in_ready}, 32'd1);
    runOp(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, 0, "afterAbort");

    for (int i = 0; i < 80; i++) begin
      mode = $urandom_range(0, 9);
      ea   = $urandom_range(1, 254);
      x    = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      if (mode < 5) begin
        eb = ea + $urandom_range(0, 4) - 2;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        y = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      end else if (mode < 7) begin
        y = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
      end else if (mode == 7) begin
        y = {~x[31], x[30:23], x[22:8], 8'($urandom)};
      end else if (mode == 8) begin
        x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), 23'($urandom)};
        y = {~x[31], 8'($urandom_range(1, 3)), 23'($urandom)};
      end else begin
        y = {1'($urandom_range(0, 1)), 8'hFF, ($urandom_range(0, 1) == 1) ? 23'd0 : 23'($urandom)};
      end
      if ($urandom_range(0, 1) == 1) begin
        r = x; x = y; y = r;
      end
      refModel(x, y, r, lat);
      runOp(x, y, r, lat, $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fp_add_ctrl.md
FP_ADD_CTRL -- requirements
Module: fp_add_ctrl

Interface
REQ-001 The block SHALL have no parameters: single-precision IEEE-754 only, 24-bit mantissa including the hidden bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b valid.
REQ-005 in_ready  output  1  block accepts operands; equals (state==IDLE).
REQ-006 a, b  input  32 each  IEEE-754 single operands.
REQ-007 out_valid  output  1  result valid; held until accepted.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 result  output  32  IEEE-754 single sum; registered.
REQ-010 busy  output  1  state!=IDLE.
REQ-011 add_sA, add_sB  output  1 each  signs to the external sign-magnitude mantissa adder.
REQ-012 add_mA, add_mB  output  24 each  aligned mantissas to the adder; driven from internal operand registers at all times.
REQ-013 add_result  input  25  adder magnitude, combinational from add_*.
REQ-014 add_s  input  1  adder result sign; +0 when magnitudes are equal and signs differ.

Function
REQ-015 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, DONE.
REQ-016 IDLE: when in_valid&&in_ready, the block SHALL register a, b and move to ALIGN, or to DONE for special operands (REQ-023).
REQ-017 Unpack rule: exponent 0 SHALL be treated as zero, with mantissa 0 and denormals flushed; otherwise the mantissa SHALL be {1,frac}.
REQ-018 ALIGN (1 cycle): operands SHALL be swapped so that A has the larger or equal exponent; mB shifted right by d=eA-eB; d>=24 forces mB=0; working exponent=eA; shifted-out bits discarded (truncation rounding).
REQ-019 ADD (1 cycle): add_result and add_s SHALL be captured into a 25-bit sum register and a sign register.
REQ-020 NORM, evaluated each cycle in priority order:
- sum==0: result=0x00000000, go to DONE.
- sum[24]: sum>>1 and exp+1; result packed; go to DONE.
- sum[23]: result packed; go to DONE.
- else: sum<<1 and exp-1, stay in NORM.
REQ-021 Overflow: exp+1==255 in NORM SHALL yield {sign,8'hFF,23'h0}.
REQ-022 Underflow: exp reaching 0 during a left shift SHALL yield result=0x00000000 and go to DONE.
REQ-023 Specials, detected in IDLE on accept, SHALL go directly to DONE:
- any NaN, or +inf plus -inf: result=0x7FC00000.
- otherwise any inf: that inf.
- both operands zero: 0x00000000.
REQ-024 Latency, with accept at cycle T:
- specials: out_valid at T+1.
- no left shift: out_valid at T+4.
- k left shifts: out_valid at T+4+k, k<=23.
REQ-025 DONE: out_valid=1 and result SHALL be stable until out_ready; on out_ready go to IDLE next cycle. No accept is possible in the same cycle as out_ready, since in_ready=0 in DONE.
REQ-026 in_valid outside IDLE SHALL be ignored; a, b are sampled only at accept.

Reset
REQ-027 While rst=1 the block SHALL hold: state=IDLE, out_valid=0, result=0, busy=0, all internal and add_* registers=0; in_ready=1 once rst deasserts.
REQ-028 Reset asserted in any state SHALL abort the operation immediately; no result is emitted and no state is retained.

Verification
REQ-029 0x3F800000+0x3F800000, out_ready=1 -> result 0x40000000, out_valid at T+4, one carry shift.
REQ-030 0x3F800000+0xBF800000 -> 0x00000000 at T+4.
REQ-031 0x3F800000+0xBF400000 -> 0x3E800000 at T+6 (2 left shifts).
REQ-032 0x4B800000+0x3F800000 (d=24) -> 0x4B800000; 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000.
REQ-033 Specials and backpressure: 0x7F800000+0xFF800000 -> 0x7FC00000 at T+1; hold out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0; in_valid pulses during busy are ignored.
REQ-034 Reset mid-operation: assert rst in NORM -> out_valid=0 and in_ready=1 after release; next operation 1.0+1.0 -> 0x40000000 with normal latency.
